// File: rtl/mpu_datapath_p_pkg.sv
// rtl/mpu_datapath_p_pkg.sv - control codes shared between the MPU datapath and its control FSM
package mpu_datapath_p_pkg;

    localparam logic [2:0] JMP_INC    = 3'd0;
    localparam logic [2:0] JMP_MEM    = 3'd1;
    localparam logic [2:0] JMP_REL_DN = 3'd2;
    localparam logic [2:0] JMP_REL_UP = 3'd3;
    localparam logic [2:0] JMP_RET    = 3'd4;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'd0,
        ALU_AND    = 3'd1,
        ALU_OR     = 3'd2,
        ALU_NOT_A  = 3'd3,
        ALU_ADD    = 3'd4,
        ALU_SUB    = 3'd5,
        ALU_INC    = 3'd6,
        ALU_DEC    = 3'd7
    } alu_op_e;

    localparam logic [1:0] ASEL_SHIFT = 2'd0;
    localparam logic [1:0] ASEL_RF    = 2'd1;
    localparam logic [1:0] ASEL_IN    = 2'd2;
    localparam logic [1:0] ASEL_MEM   = 2'd3;

    localparam logic [1:0] SHIFT_NONE = 2'd0;
    localparam logic [1:0] SHIFT_SHL  = 2'd1;
    localparam logic [1:0] SHIFT_SHR  = 2'd2;
    localparam logic [1:0] SHIFT_ROTR = 2'd3;

endpackage

// File: rtl/mpu_datapath_p_if.sv
// rtl/mpu_datapath_p_if.sv - control, status and memory-port bundle between MPU control FSM and datapath
interface mpu_datapath_p_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic [DATA_W-1:0] in;
    logic              IRload;
    logic              MRload;
    logic [DATA_W-1:0] IR;
    logic [2:0]        JMPmux;
    logic              PCload;
    logic              MemInst;
    logic              MemWr;
    logic [1:0]        Asel;
    logic              Aload;
    logic              Cload;
    logic              RFwr;
    logic [2:0]        ALUsel;
    logic [1:0]        Shiftsel;
    logic              outen;
    logic              Push;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              Aeq0;
    logic              Apos;
    logic              Cflag;
    logic              stk_err;
    logic [DATA_W-1:0] oOutput;

    modport master (
        output in, IRload, MRload, JMPmux, PCload, MemInst, MemWr, Asel, Aload,
               Cload, RFwr, ALUsel, Shiftsel, outen, Push, mem_rdata,
        input  IR, mem_addr, mem_wdata, mem_we, Aeq0, Apos, Cflag, stk_err, oOutput
    );

    modport slave (
        input  in, IRload, MRload, JMPmux, PCload, MemInst, MemWr, Asel, Aload,
               Cload, RFwr, ALUsel, Shiftsel, outen, Push, mem_rdata,
        output IR, mem_addr, mem_wdata, mem_we, Aeq0, Apos, Cflag, stk_err, oOutput
    );

endinterface

// File: rtl/mpu_datapath_p_ras.sv
// rtl/mpu_datapath_p_ras.sv - return-address LIFO with stack pointer and sticky misuse flag
module mpu_datapath_p_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         misuse_i,
    input  logic [W-1:0] push_data_i,
    output logic [W-1:0] top_o,
    output logic         empty_o,
    output logic         err_o
);
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [W-1:0]    mem_q [DEPTH];
    logic [SP_W-1:0] sp_q, sp_d;
    logic            err_q, err_d;
    logic            full;
    logic            do_push, do_pop;
    logic [SP_W-1:0] top_ptr;

    assign empty_o = (sp_q == '0);
    assign full    = (sp_q == SP_W'(DEPTH));
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty_o;
    assign top_ptr = sp_q - SP_W'(1);
    assign top_o   = mem_q[top_ptr[IDX_W-1:0]];
    assign err_o   = err_q;

    always_comb begin
        sp_d = sp_q;
        if (do_push) begin
            sp_d = sp_q + SP_W'(1);
        end else if (do_pop) begin
            sp_d = sp_q - SP_W'(1);
        end
        err_d = err_q | (push_i & full) | (pop_i & empty_o) | misuse_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack storage needs no reset: entries are only read below a valid SP.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[sp_q[IDX_W-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/mpu_datapath_p.sv
// rtl/mpu_datapath_p.sv - MPU accumulator datapath: IR/PC/MR, A+carry, RF, ALU, shifter, return stack, memory port
module mpu_datapath_p
    import mpu_datapath_p_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 6,
    parameter int RF_DEPTH    = 8,
    parameter int REL_W       = 3,
    parameter int STACK_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    mpu_datapath_p_if.slave bus
);
    localparam int IDX_W = $clog2(RF_DEPTH);

    logic [DATA_W-1:0] ir_q, a_q, a_d, out_q;
    logic [ADDR_W-1:0] pc_q, pc_d, mr_q;
    logic              c_q;
    logic [DATA_W-1:0] rf_q [RF_DEPTH];

    logic [IDX_W-1:0]  rf_idx;
    logic [DATA_W-1:0] rf_rd, alu_res, sh_res;
    logic              alu_c;
    alu_op_e           alu_op;
    logic [DATA_W:0]   sum_ab, diff_ab, inc_a, dec_a;
    logic [ADDR_W-1:0] pc_inc, rel_off, ras_top;
    logic              call_w, ret_w, misuse_w, ras_empty;

    assign rf_idx  = ir_q[IDX_W-1:0];
    assign rf_rd   = rf_q[rf_idx];
    assign alu_op  = alu_op_e'(bus.ALUsel);
    assign sum_ab  = {1'b0, a_q} + {1'b0, rf_rd};
    assign diff_ab = {1'b0, a_q} - {1'b0, rf_rd};
    assign inc_a   = {1'b0, a_q} + (DATA_W + 1)'(1);
    assign dec_a   = {1'b0, a_q} - (DATA_W + 1)'(1);

    // Subtract-type carry is the inverse of the borrow out of the extra bit.
    always_comb begin
        alu_res = rf_rd;
        alu_c   = 1'b0;
        case (alu_op)
            ALU_PASS_B: alu_res = rf_rd;
            ALU_AND:    alu_res = a_q & rf_rd;
            ALU_OR:     alu_res = a_q | rf_rd;
            ALU_NOT_A:  alu_res = ~a_q;
            ALU_ADD:    {alu_c, alu_res} = sum_ab;
            ALU_SUB:    begin alu_res = diff_ab[DATA_W-1:0]; alu_c = ~diff_ab[DATA_W]; end
            ALU_INC:    {alu_c, alu_res} = inc_a;
            ALU_DEC:    begin alu_res = dec_a[DATA_W-1:0]; alu_c = ~dec_a[DATA_W]; end
            default:    alu_res = rf_rd;
        endcase
    end

    always_comb begin
        sh_res = alu_res;
        case (bus.Shiftsel)
            SHIFT_SHL:  sh_res = {alu_res[DATA_W-2:0], 1'b0};
            SHIFT_SHR:  sh_res = {1'b0, alu_res[DATA_W-1:1]};
            SHIFT_ROTR: sh_res = {alu_res[0], alu_res[DATA_W-1:1]};
            default:    sh_res = alu_res;
        endcase
    end

    always_comb begin
        a_d = sh_res;
        case (bus.Asel)
            ASEL_RF:  a_d = rf_rd;
            ASEL_IN:  a_d = bus.in;
            ASEL_MEM: a_d = bus.mem_rdata;
            default:  a_d = sh_res;
        endcase
    end

    assign pc_inc   = pc_q + ADDR_W'(1);
    assign rel_off  = ADDR_W'(ir_q[REL_W-1:0]);
    assign call_w   = bus.PCload & bus.Push & (bus.JMPmux == JMP_MEM);
    assign ret_w    = bus.PCload & (bus.JMPmux == JMP_RET);
    assign misuse_w = bus.PCload & bus.Push & (bus.JMPmux != JMP_MEM);

    always_comb begin
        pc_d = pc_q;
        case (bus.JMPmux)
            JMP_INC:    pc_d = pc_inc;
            JMP_MEM:    pc_d = bus.mem_rdata[ADDR_W-1:0];
            JMP_REL_DN: pc_d = pc_q - rel_off;
            JMP_REL_UP: pc_d = pc_q + rel_off;
            JMP_RET:    pc_d = ras_empty ? pc_q : ras_top;
            default:    pc_d = pc_q;
        endcase
    end

    mpu_datapath_p_ras #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (call_w),
        .pop_i       (ret_w),
        .misuse_i    (misuse_w),
        .push_data_i (pc_inc),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .err_o       (bus.stk_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q  <= '0;
            pc_q  <= '0;
            mr_q  <= '0;
            a_q   <= '0;
            c_q   <= 1'b0;
            out_q <= '0;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (bus.IRload) ir_q  <= bus.mem_rdata;
            if (bus.MRload) mr_q  <= bus.mem_rdata[ADDR_W-1:0];
            if (bus.PCload) pc_q  <= pc_d;
            if (bus.Aload)  a_q   <= a_d;
            if (bus.Cload)  c_q   <= alu_c;
            if (bus.outen)  out_q <= a_q;
            if (bus.RFwr)   rf_q[rf_idx] <= a_q;
        end
    end

    assign bus.IR        = ir_q;
    assign bus.mem_addr  = bus.MemInst ? mr_q : pc_q;
    assign bus.mem_wdata = a_q;
    assign bus.mem_we    = bus.MemWr;
    assign bus.Aeq0      = (a_q == '0);
    assign bus.Apos      = ~a_q[DATA_W-1];
    assign bus.Cflag     = c_q;
    assign bus.oOutput   = out_q;

endmodule

// File: tb/tb_mpu_datapath_p.sv
// tb/tb_mpu_datapath_p.sv - self-checking bench for mpu_datapath_p with directed and randomized scenarios
module tb_mpu_datapath_p;
    import mpu_datapath_p_pkg::*;

    localparam int DW = 8;
    localparam int AW = 6;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mpu_datapath_p_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mpu_datapath_p #(
        .DATA_W(DW), .ADDR_W(AW), .RF_DEPTH(8), .REL_W(3), .STACK_DEPTH(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.in = '0; bus.IRload = 0; bus.MRload = 0; bus.JMPmux = 3'd5; bus.PCload = 0;
        bus.MemInst = 0; bus.MemWr = 0; bus.Asel = 2'd0; bus.Aload = 0; bus.Cload = 0;
        bus.RFwr = 0; bus.ALUsel = 3'd0; bus.Shiftsel = 2'd0; bus.outen = 0; bus.Push = 0;
        bus.mem_rdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_pc(input int v);
        bus.mem_rdata = DW'(v); bus.JMPmux = JMP_MEM; bus.PCload = 1; tick();
    endtask

    task automatic set_ir(input int v);
        bus.mem_rdata = DW'(v); bus.IRload = 1; tick();
    endtask

    task automatic load_a(input int v);
        bus.in = DW'(v); bus.Asel = ASEL_IN; bus.Aload = 1; tick();
    endtask

    task automatic write_rf(input int idx, input int v);
        set_ir(idx);
        load_a(v);
        bus.RFwr = 1; tick();
    endtask

    function automatic logic [8:0] ref_alu(input int op, input int a, input int b, input int sh);
        int r;
        int c;
        c = 0;
        r = 0;
        case (op)
            0: r = b;
            1: r = a & b;
            2: r = a | b;
            3: r = 255 - a;
            4: begin r = a + b; c = (r > 255) ? 1 : 0; r = r % 256; end
            5: begin c = (a >= b) ? 1 : 0; r = (a - b + 256) % 256; end
            6: begin r = a + 1; c = (r > 255) ? 1 : 0; r = r % 256; end
            default: begin c = (a != 0) ? 1 : 0; r = (a + 255) % 256; end
        endcase
        case (sh)
            1: r = (r * 2) % 256;
            2: r = r / 2;
            3: r = (r / 2) + ((r % 2) * 128);
            default: r = r;
        endcase
        return 9'(c * 256 + r);
    endfunction

    task automatic test_reset();
        idle();
        #12;
        checks++; if (bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_a: got %h expected 00", bus.mem_wdata); end
        checks++; if (bus.mem_addr !== 6'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", bus.mem_addr); end
        checks++; if (bus.IR !== 8'h00 || bus.oOutput !== 8'h00) begin errors++; $display("FAIL reset_ir_out: got IR=%h out=%h expected 00/00", bus.IR, bus.oOutput); end
        checks++; if (bus.Cflag !== 1'b0 || bus.stk_err !== 1'b0 || bus.Aeq0 !== 1'b1) begin errors++; $display("FAIL reset_flags: got C=%b err=%b eq0=%b expected 0/0/1", bus.Cflag, bus.stk_err, bus.Aeq0); end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midrun();
        load_a(8'h5A);
        set_pc(8'h2B);
        bus.outen = 1; tick();
        bus.JMPmux = JMP_RET; bus.PCload = 1; tick();
        checks++; if (bus.mem_wdata !== 8'h5A || bus.oOutput !== 8'h5A || bus.stk_err !== 1'b1) begin errors++; $display("FAIL midrun_setup: got A=%h out=%h err=%b expected 5a/5a/1", bus.mem_wdata, bus.oOutput, bus.stk_err); end
        reset = 1'b0;
        #2;
        checks++; if (bus.mem_wdata !== 8'h00 || bus.mem_addr !== 6'h00) begin errors++; $display("FAIL midrun_a_pc: got A=%h PC=%h expected 00/00", bus.mem_wdata, bus.mem_addr); end
        checks++; if (bus.oOutput !== 8'h00 || bus.stk_err !== 1'b0) begin errors++; $display("FAIL midrun_out_err: got out=%h err=%b expected 00/0", bus.oOutput, bus.stk_err); end
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_pc_wrap();
        set_pc(8'h3F);
        bus.JMPmux = JMP_INC; bus.PCload = 1; tick();
        checks++; if (bus.mem_addr !== 6'h00) begin errors++; $display("FAIL pc_wrap_inc: got %h expected 00", bus.mem_addr); end
        set_pc(8'h01);
        set_ir(8'h03);
        bus.JMPmux = JMP_REL_DN; bus.PCload = 1; tick();
        checks++; if (bus.mem_addr !== 6'h3E) begin errors++; $display("FAIL pc_wrap_reldn: got %h expected 3e", bus.mem_addr); end
        bus.JMPmux = JMP_REL_UP; bus.PCload = 1; tick();
        checks++; if (bus.mem_addr !== 6'h01) begin errors++; $display("FAIL pc_wrap_relup: got %h expected 01", bus.mem_addr); end
        bus.JMPmux = 3'd6; bus.PCload = 1; tick();
        checks++; if (bus.mem_addr !== 6'h01) begin errors++; $display("FAIL pc_hold: got %h expected 01", bus.mem_addr); end
        bus.JMPmux = JMP_INC; tick();
        checks++; if (bus.mem_addr !== 6'h01) begin errors++; $display("FAIL pc_no_load: got %h expected 01", bus.mem_addr); end
    endtask

    task automatic test_alu_carry();
        write_rf(2, 8'h01);
        load_a(8'hFF);
        bus.ALUsel = ALU_ADD; bus.Asel = ASEL_SHIFT; bus.Aload = 1; bus.Cload = 1; tick();
        checks++; if (bus.mem_wdata !== 8'h00 || bus.Cflag !== 1'b1 || bus.Aeq0 !== 1'b1) begin errors++; $display("FAIL alu_add_carry: got A=%h C=%b eq0=%b expected 00/1/1", bus.mem_wdata, bus.Cflag, bus.Aeq0); end
        bus.ALUsel = ALU_SUB; bus.Asel = ASEL_SHIFT; bus.Aload = 1; bus.Cload = 1; tick();
        checks++; if (bus.mem_wdata !== 8'hFF || bus.Cflag !== 1'b0 || bus.Apos !== 1'b0) begin errors++; $display("FAIL alu_sub_borrow: got A=%h C=%b pos=%b expected ff/0/0", bus.mem_wdata, bus.Cflag, bus.Apos); end
        load_a(8'h77);
        bus.RFwr = 1; bus.Asel = ASEL_RF; bus.Aload = 1; tick();
        checks++; if (bus.mem_wdata !== 8'h01) begin errors++; $display("FAIL rf_read_old: got %h expected 01", bus.mem_wdata); end
        bus.Asel = ASEL_RF; bus.Aload = 1; tick();
        checks++; if (bus.mem_wdata !== 8'h77) begin errors++; $display("FAIL rf_write_landed: got %h expected 77", bus.mem_wdata); end
    endtask

    task automatic test_call_ret();
        do_reset();
        set_pc(8'h10);
        bus.mem_rdata = 8'h20; bus.JMPmux = JMP_MEM; bus.PCload = 1; bus.Push = 1; tick();
        checks++; if (bus.mem_addr !== 6'h20) begin errors++; $display("FAIL call_target: got %h expected 20", bus.mem_addr); end
        bus.JMPmux = JMP_RET; bus.PCload = 1; tick();
        checks++; if (bus.mem_addr !== 6'h11 || bus.stk_err !== 1'b0) begin errors++; $display("FAIL ret_addr: got PC=%h err=%b expected 11/0", bus.mem_addr, bus.stk_err); end
        bus.Push = 1; tick();
        checks++; if (bus.stk_err !== 1'b0) begin errors++; $display("FAIL push_no_pcload: got err=%b expected 0", bus.stk_err); end
    endtask

    task automatic test_stack_overflow();
        int exp_ret [4] = '{8'h19, 8'h11, 8'h09, 8'h01};
        do_reset();
        set_pc(8'h00);
        for (int i = 1; i <= 5; i++) begin
            bus.mem_rdata = DW'(i * 8); bus.JMPmux = JMP_MEM; bus.PCload = 1; bus.Push = 1; tick();
            checks++; if (bus.mem_addr !== AW'(i * 8)) begin errors++; $display("FAIL call_%0d_pc: got %h expected %h", i, bus.mem_addr, AW'(i * 8)); end
            checks++; if (bus.stk_err !== (i == 5)) begin errors++; $display("FAIL call_%0d_err: got %b expected %b", i, bus.stk_err, (i == 5)); end
        end
        for (int i = 0; i < 4; i++) begin
            bus.JMPmux = JMP_RET; bus.PCload = 1; tick();
            checks++; if (bus.mem_addr !== AW'(exp_ret[i])) begin errors++; $display("FAIL ret_%0d_pc: got %h expected %h", i, bus.mem_addr, AW'(exp_ret[i])); end
        end
        bus.JMPmux = JMP_RET; bus.PCload = 1; tick();
        checks++; if (bus.mem_addr !== 6'h01 || bus.stk_err !== 1'b1) begin errors++; $display("FAIL ret_underflow: got PC=%h err=%b expected 01/1", bus.mem_addr, bus.stk_err); end
    endtask

    task automatic test_push_misuse();
        do_reset();
        set_pc(8'h05);
        bus.JMPmux = JMP_INC; bus.PCload = 1; bus.Push = 1; tick();
        checks++; if (bus.mem_addr !== 6'h06 || bus.stk_err !== 1'b1) begin errors++; $display("FAIL push_misuse: got PC=%h err=%b expected 06/1", bus.mem_addr, bus.stk_err); end
        bus.JMPmux = JMP_RET; bus.PCload = 1; tick();
        checks++; if (bus.mem_addr !== 6'h06) begin errors++; $display("FAIL misuse_no_push: got %h expected 06", bus.mem_addr); end
    endtask

    task automatic test_mem_port();
        bus.mem_rdata = 8'hC7; bus.MRload = 1; tick();
        load_a(8'hC3);
        bus.MemInst = 1; bus.MemWr = 1;
        #1;
        checks++; if (bus.mem_addr !== 6'h07 || bus.mem_wdata !== 8'hC3 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL mem_write: got addr=%h wdata=%h we=%b expected 07/c3/1", bus.mem_addr, bus.mem_wdata, bus.mem_we); end
        tick();
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL mem_we_idle: got %b expected 0", bus.mem_we); end
        bus.MemInst = 1; bus.mem_rdata = 8'h3C; bus.Asel = ASEL_MEM; bus.Aload = 1; tick();
        checks++; if (bus.mem_wdata !== 8'h3C) begin errors++; $display("FAIL mem_readback: got %h expected 3c", bus.mem_wdata); end
        bus.outen = 1; tick();
        checks++; if (bus.oOutput !== 8'h3C) begin errors++; $display("FAIL out_reg: got %h expected 3c", bus.oOutput); end
        set_ir(8'hA5);
        checks++; if (bus.IR !== 8'hA5) begin errors++; $display("FAIL ir_load: got %h expected a5", bus.IR); end
    endtask

    task automatic test_random_alu();
        int a, b, idx, op, sh, cl;
        logic [8:0] exp;
        logic m_c;
        m_c = 1'b0;
        for (int i = 0; i < 40; i++) begin
            a   = $urandom_range(0, 255);
            b   = $urandom_range(0, 255);
            idx = $urandom_range(0, 7);
            op  = $urandom_range(0, 7);
            sh  = $urandom_range(0, 3);
            cl  = (i == 0) ? 1 : $urandom_range(0, 1);
            if (i % 8 == 0) a = 255;
            if (i % 8 == 1) b = a;
            write_rf(idx, b);
            load_a(a);
            exp = ref_alu(op, a, b, sh);
            if (cl == 1) m_c = exp[8];
            bus.ALUsel = 3'(op); bus.Shiftsel = 2'(sh); bus.Asel = ASEL_SHIFT;
            bus.Aload = 1; bus.Cload = (cl == 1); tick();
            checks++; if (bus.mem_wdata !== exp[7:0]) begin errors++; $display("FAIL rand_alu_a[%0d] op=%0d sh=%0d a=%h b=%h: got %h expected %h", i, op, sh, a, b, bus.mem_wdata, exp[7:0]); end
            checks++; if (bus.Cflag !== m_c) begin errors++; $display("FAIL rand_alu_c[%0d] op=%0d a=%h b=%h: got %b expected %b", i, op, a, b, bus.Cflag, m_c); end
            checks++; if (bus.Aeq0 !== (exp[7:0] == 8'h00) || bus.Apos !== ~exp[7]) begin errors++; $display("FAIL rand_alu_flags[%0d]: got eq0=%b pos=%b for A=%h", i, bus.Aeq0, bus.Apos, exp[7:0]); end
        end
    endtask

    task automatic test_random_stack();
        int stk [$];
        int m_pc, kind, tgt;
        logic m_err;
        do_reset();
        set_pc(0);
        m_pc = 0;
        m_err = 1'b0;
        for (int i = 0; i < 50; i++) begin
            kind = $urandom_range(0, 2);
            tgt  = $urandom_range(0, 63);
            if (kind == 0) begin
                bus.mem_rdata = DW'(tgt); bus.JMPmux = JMP_MEM; bus.PCload = 1; bus.Push = 1;
                if (stk.size() < 4) stk.push_back((m_pc + 1) % 64);
                else m_err = 1'b1;
                m_pc = tgt;
            end else if (kind == 1) begin
                bus.JMPmux = JMP_RET; bus.PCload = 1;
                if (stk.size() > 0) m_pc = stk.pop_back();
                else m_err = 1'b1;
            end else begin
                bus.JMPmux = JMP_INC; bus.PCload = 1;
                m_pc = (m_pc + 1) % 64;
            end
            tick();
            checks++; if (bus.mem_addr !== AW'(m_pc) || bus.stk_err !== m_err) begin errors++; $display("FAIL rand_stack[%0d] kind=%0d: got PC=%h err=%b expected %h/%b", i, kind, bus.mem_addr, bus.stk_err, AW'(m_pc), m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_reset_midrun();
        test_pc_wrap();
        test_alu_carry();
        test_call_ret();
        test_stack_overflow();
        test_push_misuse();
        test_mem_port();
        test_random_alu();
        test_random_stack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
